// File: rtl/fb_pkg.sv
// Shared timing constants, framebuffer geometry and types for the framebuffer arbiter.
// DOUBLE_BUFFER_EN adds one bank-select bit to the RAM address.
package fb_pkg;

  localparam logic [9:0] H_ACT_START  = 10'd144;
  localparam logic [9:0] H_ACT_END    = 10'd783;
  localparam logic [9:0] V_ACT_START  = 10'd35;
  localparam logic [9:0] V_ACT_END    = 10'd514;
  localparam logic [9:0] H_LEAD       = 10'd2;
  localparam logic [9:0] V_FRAME_DONE = 10'd516;
  localparam int         SCALE_SHIFT  = 2;

  // Reads are issued H_LEAD clocks ahead of the visible column they feed.
  localparam logic [9:0] H_RD_START = H_ACT_START - H_LEAD;
  localparam logic [9:0] H_RD_END   = H_ACT_END - H_LEAD;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

`ifdef DOUBLE_BUFFER_EN
  localparam int BUF_BITS = 1;
`else
  localparam int BUF_BITS = 0;
`endif

  localparam int PIX_W_DEF = 8;
  localparam int X_W_DEF   = 8;
  localparam int Y_W_DEF   = 7;

  typedef logic [PIX_W_DEF-1:0]                   pixel_t;
  typedef logic [X_W_DEF+Y_W_DEF+BUF_BITS-1:0]    addr_t;

  function automatic logic in_bounds(input logic [15:0] x, input logic [15:0] y);
    return (x < 16'(FB_W)) && (y < 16'(FB_H));
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO that posts pixel writes until the RAM has a free cycle.
// Head entry is visible combinationally so the arbiter can inspect it before popping.
module fb_write_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (!push_ok && pop_ok) begin
        count_reg <= count_reg - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port framebuffer RAM between display scan-out reads and posted pixel writes.
// Optional DOUBLE_BUFFER_EN adds swap_req/front_sel and a bank bit on mem_addr.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PIX_W      = 8,
  parameter int X_W        = 8,
  parameter int Y_W        = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   hCount,
  input  logic [9:0]                   vCount,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [X_W-1:0]               wr_x,
  input  logic [Y_W-1:0]               wr_y,
  input  logic [PIX_W-1:0]             wr_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [X_W+Y_W+BUF_BITS-1:0]  mem_addr,
  output logic [PIX_W-1:0]             mem_wdata,
  input  logic [PIX_W-1:0]             mem_rdata,
  output logic [PIX_W-1:0]             pix_rgb,
  output logic                         frame_done
`ifdef DOUBLE_BUFFER_EN
  ,
  input  logic                         swap_req,
  output logic                         front_sel
`endif
);

  localparam int ADDR_W  = X_W + Y_W + BUF_BITS;
  localparam int ENTRY_W = Y_W + X_W + PIX_W;

  logic              rd_slot;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  logic [ENTRY_W-1:0] head;
  logic [X_W-1:0]     head_x;
  logic [Y_W-1:0]     head_y;
  logic [PIX_W-1:0]   head_data;
  logic               head_ok;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  logic slot_d1_reg;
  logic slot_d2_reg;
  logic frame_match;
  logic match_prev_reg;

  // Read-slot decode is purely range based, so counter wrap needs no care.
  always_comb begin
    rd_slot = (hCount >= H_RD_START) && (hCount <= H_RD_END) &&
              (vCount >= V_ACT_START) && (vCount <= V_ACT_END);
    rd_x    = X_W'((hCount - H_RD_START) >> SCALE_SHIFT);
    rd_y    = Y_W'((vCount - V_ACT_START) >> SCALE_SHIFT);
  end

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .pop   (fifo_pop),
    .din   ({wr_y, wr_x, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign fifo_pop  = !rd_slot && !fifo_empty;
  assign head_y    = head[ENTRY_W-1 -: Y_W];
  assign head_x    = head[PIX_W +: X_W];
  assign head_data = head[PIX_W-1:0];
  assign head_ok   = in_bounds(16'(head_x), 16'(head_y));

`ifdef DOUBLE_BUFFER_EN
  logic front_sel_reg;
  logic swap_pending_reg;

  // Scan-out reads the front bank; game logic draws into the back bank.
  assign rd_addr   = {front_sel_reg, rd_y, rd_x};
  assign wr_addr   = {~front_sel_reg, head_y, head_x};
  assign front_sel = front_sel_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
    end else if (frame_done) begin
      if (swap_pending_reg) begin
        front_sel_reg <= ~front_sel_reg;
      end
      swap_pending_reg <= swap_req;
    end else if (swap_req) begin
      swap_pending_reg <= 1'b1;
    end
  end
`else
  assign rd_addr = {rd_y, rd_x};
  assign wr_addr = {head_y, head_x};
`endif

  // Pulse only on the first clock of the match, even if the counters stall there.
  assign frame_match = (hCount == 10'd0) && (vCount == V_FRAME_DONE);
  assign frame_done  = frame_match && !match_prev_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_d1_reg    <= 1'b0;
      slot_d2_reg    <= 1'b0;
      match_prev_reg <= 1'b0;
      pix_rgb        <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      slot_d1_reg    <= rd_slot;
      slot_d2_reg    <= slot_d1_reg;
      match_prev_reg <= frame_match;
      pix_rgb        <= slot_d2_reg ? mem_rdata : '0;
      if (rd_slot) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
      end else if (fifo_pop && head_ok) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= head_data;
      end else begin
        // Idle, or an off-screen head entry being dropped.
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a behavioural single-port RAM.
// Exercises the DOUBLE_BUFFER_EN bank swap when that macro is defined.
module tb_framebuffer_arbiter;

`ifdef DOUBLE_BUFFER_EN
  localparam int ADDR_W = 16;
`else
  localparam int ADDR_W = 15;
`endif

  logic              clk;
  logic              reset;
  logic [9:0]        hCount;
  logic [9:0]        vCount;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_x;
  logic [6:0]        wr_y;
  logic [7:0]        wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [7:0]        pix_rgb;
  logic              frame_done;
`ifdef DOUBLE_BUFFER_EN
  logic              swap_req;
  logic              front_sel;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]        ram [int];
  logic [ADDR_W-1:0] wlog_a [$];
  logic [7:0]        wlog_d [$];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [7:0]        pl_data = '0;
  logic [ADDR_W-1:0] wbank;

  framebuffer_arbiter #(
    .FIFO_DEPTH (8),
    .PIX_W      (8),
    .X_W        (8),
    .Y_W        (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done)
`ifdef DOUBLE_BUFFER_EN
    ,
    .swap_req   (swap_req),
    .front_sel  (front_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read; every write is logged in order.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[int'(pl_addr)] = pl_data;
    end else if (mem_en && mem_we) begin
      ram[int'(mem_addr)] = mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end else if (mem_en) begin
      mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 8'h00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (hCount == 10'd799) begin
      hCount = 10'd0;
      vCount = (vCount == 10'd524) ? 10'd0 : 10'(vCount + 10'd1);
    end else begin
      hCount = 10'(hCount + 10'd1);
    end
    #1;
  endtask

  task automatic goto(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, hCount, vCount);
    end
  endtask

  task automatic push(input int x, input int y, input int d);
    wr_valid = 1'b1;
    wr_x     = 8'(x);
    wr_y     = 7'(y);
    wr_data  = 8'(d);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    cyc();
    pl_en   = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int y, input int x);
    logic [6:0] yv;
    logic [7:0] xv;
    yv = 7'(y);
    xv = 8'(x);
    return ADDR_W'({yv, xv});
  endfunction

  // Row 0 holds 1C at column 0 and 55 at column 1; visible 3 clocks after the read slot.
  function automatic logic [7:0] exp_pix(input int h, input bit row0);
    if (!row0) return 8'h00;
    if (h >= 145 && h <= 148) return 8'h1C;
    if (h >= 149 && h <= 152) return 8'h55;
    return 8'h00;
  endfunction

  initial begin
    int we_cnt;
    int base;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_data  = '0;
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b0;
    wbank    = ADDR_W'(1) << (ADDR_W - 1);
`else
    wbank    = '0;
`endif
    goto(300, 100);
    repeat (2) cyc();

    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_ready", wr_ready, 1);
`ifdef DOUBLE_BUFFER_EN
    check("rst_front_sel", front_sel, 0);
`endif

    // Five writes posted during active video stay queued, then a mid-line reset drops them.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(i + 1, 1, 8'h10 + i);
      cyc();
    end
    wr_valid = 1'b0;
    check("fifo5_wr_ready", wr_ready, 1);
    check("fifo5_no_we", mem_we, 0);
    reset = 1'b1;
    repeat (3) cyc();
    check("rst2_mem_en", mem_en, 0);
    check("rst2_mem_we", mem_we, 0);
    check("rst2_pix_rgb", pix_rgb, 0);
    check("rst2_wr_ready", wr_ready, 1);
    reset = 1'b0;
    goto(10, 520);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_we) we_cnt++;
    end
    check("rst2_fifo_discarded", we_cnt, 0);

    // Single write in vertical blank reaches the RAM two clocks after acceptance.
    goto(10, 520);
    push(0, 0, 8'hE0);
    check("vb_wr_ready", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    check("vb_we_c1", mem_we, 0);
    cyc();
    check("vb_we_c2", mem_we, 1);
    check("vb_en_c2", mem_en, 1);
    check("vb_addr_c2", mem_addr, wbank | mk_addr(0, 0));
    check("vb_wdata_c2", mem_wdata, 8'hE0);
    cyc();
    check("vb_we_c3", mem_we, 0);
    check("vb_en_c3", mem_en, 0);
    check("vb_addr_hold", mem_addr, wbank | mk_addr(0, 0));
    check("vb_wdata_hold", mem_wdata, 8'hE0);

    // Scan-out of rows 0 and 1 with the read-slot pipeline alignment.
    preload(mk_addr(0, 0), 8'h1C);
    preload(mk_addr(0, 1), 8'h55);
    for (int line = 0; line < 3; line++) begin
      int  vv;
      bit  row0;
      vv   = (line == 0) ? 35 : ((line == 1) ? 38 : 39);
      row0 = (vv <= 38);
      goto(130, vv);
      for (int i = 0; i < 661; i++) begin
        check("scan_pix", pix_rgb, exp_pix(hCount, row0));
        if (hCount == 10'd143 && line == 0) begin
          check("scan_rd_en", mem_en, 1);
          check("scan_rd_we", mem_we, 0);
          check("scan_rd_addr0", mem_addr, mk_addr(0, 0));
        end
        if (hCount == 10'd147 && line == 0) begin
          check("scan_rd_addr1", mem_addr, mk_addr(0, 1));
        end
        cyc();
      end
    end

    // Fill the FIFO inside an active line; nothing drains until the read slots end.
    goto(300, 40);
    base = wlog_a.size();
    for (int i = 0; i < 8; i++) begin
      push(10 + i, 3, 8'hA0 + i);
      check("fill_wr_ready", wr_ready, 1);
      cyc();
    end
    push(50, 3, 8'hFF);
    check("full_wr_ready", wr_ready, 0);
    cyc();
    wr_valid = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 1000 && hCount != 10'd783; i++) begin
      if (mem_we) we_cnt++;
      cyc();
    end
    check("fill_no_we_in_slots", we_cnt, 0);
    check("drain_first_h", hCount, 783);
    check("drain_first_we", mem_we, 1);
    check("drain_first_addr", mem_addr, wbank | mk_addr(3, 10));
    check("drain_first_data", mem_wdata, 8'hA0);
    check("drain_wr_ready", wr_ready, 1);
    repeat (15) cyc();
    check("drain_count", wlog_a.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < wlog_a.size()) begin
        check("drain_order_addr", wlog_a[base + i], wbank | mk_addr(3, 10 + i));
        check("drain_order_data", wlog_d[base + i], 8'hA0 + i);
      end
    end

    // Off-screen entries are popped without touching the RAM.
    goto(10, 520);
    base = wlog_a.size();
    push(200, 10, 8'h11);
    cyc();
    push(5, 10, 8'h22);
    cyc();
    check("oob_x_en", mem_en, 0);
    check("oob_x_we", mem_we, 0);
    push(3, 120, 8'h33);
    cyc();
    wr_valid = 1'b0;
    check("oob_valid_we", mem_we, 1);
    check("oob_valid_addr", mem_addr, wbank | mk_addr(10, 5));
    check("oob_valid_data", mem_wdata, 8'h22);
    cyc();
    check("oob_y_en", mem_en, 0);
    repeat (5) cyc();
    check("oob_write_count", wlog_a.size() - base, 1);

`ifdef DOUBLE_BUFFER_EN
    // Swap requested mid-frame takes effect at the end of the frame_done cycle.
    goto(400, 300);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    cyc();
    check("db_pending_front", front_sel, 0);
`endif

    goto(798, 515);
    check("fd_before", frame_done, 0);
    cyc();
    check("fd_799", frame_done, 0);
    cyc();
    check("fd_pulse_h", hCount, 0);
    check("fd_pulse", frame_done, 1);
`ifdef DOUBLE_BUFFER_EN
    check("db_front_in_fd", front_sel, 0);
    swap_req = 1'b1;
`endif
    cyc();
    check("fd_after", frame_done, 0);
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b0;
    check("db_front_toggled", front_sel, 1);
    wbank = '0;
    push(2, 2, 8'h99);
    cyc();
    wr_valid = 1'b0;
    cyc();
    check("db_back_we", mem_we, 1);
    check("db_back_addr", mem_addr, wbank | mk_addr(2, 2));
    goto(798, 515);
    cyc();
    cyc();
    check("db_fd2", frame_done, 1);
    cyc();
    check("db_front_back", front_sel, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
